// File: rtl/data_memory_responder.sv
// Single-port word memory behind a valid/ready request/response handshake with a fixed
// response latency. Define DATA_MEMORY_ERROR_CHECK_EN to reject misaligned or out-of-range addresses.
module data_memory_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic        request_write,
  input  logic [31:0] request_address,
  input  logic [31:0] request_write_data,
  output logic        response_valid,
  input  logic        response_ready,
  output logic [31:0] response_read_data,
  output logic        response_error
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  logic        req_write_reg;
  logic [31:0] req_addr_reg;
  logic [31:0] req_wdata_reg;
  logic        resp_zero_reg;
  logic        resp_error_reg;
  logic [31:0] mem_rdata_reg;
  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          enter_respond;
  logic          sel_write;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [AW-1:0] sel_index;
  logic          addr_error;

  assign accept = (state_reg == IDLE) && request_valid;

  // With no wait states the memory is accessed on the acceptance edge itself,
  // so the live request is used until it has been captured.
  assign sel_write = (state_reg == IDLE) ? request_write      : req_write_reg;
  assign sel_addr  = (state_reg == IDLE) ? request_address    : req_addr_reg;
  assign sel_wdata = (state_reg == IDLE) ? request_write_data : req_wdata_reg;
  assign sel_index = sel_addr[AW+1:2];

  assign enter_respond = !reset && (state_next == RESPOND) && (state_reg != RESPOND);

`ifdef DATA_MEMORY_ERROR_CHECK_EN
  assign addr_error = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= 30'(DEPTH));
`else
  logic unused_addr_bits;
  assign addr_error       = 1'b0;
  assign unused_addr_bits = ^{sel_addr[31:AW+2], sel_addr[1:0]};
`endif

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (request_valid) begin
          if (WAIT_STATES > 0) begin
            state_next    = WAIT;
            wait_cnt_next = 4'(WAIT_STATES - 1);
          end else begin
            state_next = RESPOND;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_reg == 4'd0) begin
          state_next = RESPOND;
        end else begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
      end
      RESPOND: begin
        if (response_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      wait_cnt_reg   <= 4'd0;
      req_write_reg  <= 1'b0;
      req_addr_reg   <= 32'd0;
      req_wdata_reg  <= 32'd0;
      resp_zero_reg  <= 1'b1;
      resp_error_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (accept) begin
        req_write_reg <= request_write;
        req_addr_reg  <= request_address;
        req_wdata_reg <= request_write_data;
      end
      if (enter_respond) begin
        resp_zero_reg  <= sel_write || addr_error;
        resp_error_reg <= addr_error;
      end
    end
  end

  // Storage has no reset so it maps onto block RAM; read is registered.
  always_ff @(posedge clock) begin
    if (enter_respond) begin
      if (sel_write && !addr_error) begin
        mem[sel_index] <= sel_wdata;
      end
      mem_rdata_reg <= mem[sel_index];
    end
  end

  assign request_ready      = (state_reg == IDLE);
  assign response_valid     = (state_reg == RESPOND);
  assign response_error     = response_valid && resp_error_reg;
  assign response_read_data = (response_valid && !resp_zero_reg) ? mem_rdata_reg : 32'd0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized self-checking bench for data_memory_responder against an array-based
// memory model; a second zero-wait-state instance covers back-to-back throughput.
module tb_data_memory_responder;

  localparam int DEPTH = 64;
  localparam int WS    = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        request_valid, request_ready, request_write;
  logic [31:0] request_address, request_write_data;
  logic        response_valid, response_ready, response_error;
  logic [31:0] response_read_data;

  logic        request_valid_z, request_ready_z, request_write_z;
  logic [31:0] request_address_z, request_write_data_z;
  logic        response_valid_z, response_ready_z, response_error_z;
  logic [31:0] response_read_data_z;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_mem_z [4];
  int          checks = 0;
  int          errors = 0;
  int          txn_count = 0;

  always #5 clock = ~clock;

  data_memory_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset),
    .request_valid(request_valid), .request_ready(request_ready),
    .request_write(request_write), .request_address(request_address),
    .request_write_data(request_write_data),
    .response_valid(response_valid), .response_ready(response_ready),
    .response_read_data(response_read_data), .response_error(response_error)
  );

  data_memory_responder #(.DEPTH(16), .WAIT_STATES(0)) dut_z (
    .clock(clock), .reset(reset),
    .request_valid(request_valid_z), .request_ready(request_ready_z),
    .request_write(request_write_z), .request_address(request_address_z),
    .request_write_data(request_write_data_z),
    .response_valid(response_valid_z), .response_ready(response_ready_z),
    .response_read_data(response_read_data_z), .response_error(response_error_z)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, request_ready, 1);
    check({tag, "_resp_valid"}, response_valid, 0);
    check({tag, "_resp_data"}, response_read_data, 0);
    check({tag, "_resp_error"}, response_error, 0);
  endtask

  // One full transaction; hold = cycles response_ready stays low in RESPOND.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int hold);
    logic [31:0] exp_data;
    logic        exp_err;
    int          idx;
    exp_err = 1'b0;
`ifdef DATA_MEMORY_ERROR_CHECK_EN
    exp_err = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
`endif
    idx      = int'((addr / 4) % DEPTH);
    exp_data = (wr || exp_err) ? 32'd0 : model_mem[idx];
    if (wr && !exp_err) model_mem[idx] = wd;
    txn_count++;
    $display("txn %0d %s addr=%h wdata=%h exp_data=%h exp_err=%0b hold=%0d",
             txn_count, wr ? "store" : "load ", addr, wd, exp_data, exp_err, hold);

    check("idle_ready", request_ready, 1);
    request_valid      = 1'b1;
    request_write      = wr;
    request_address    = addr;
    request_write_data = wd;
    response_ready     = (hold == 0);
    tick();
    // Scramble the request bus; the captured request must not change.
    request_valid      = 1'b0;
    request_write      = 1'($urandom);
    request_address    = $urandom;
    request_write_data = $urandom;
    for (int k = 0; k < WS; k++) begin
      check("wait_valid", response_valid, 0);
      check("wait_busy", request_ready, 0);
      check("wait_data", response_read_data, 0);
      tick();
    end
    check("resp_valid", response_valid, 1);
    check("resp_data", response_read_data, exp_data);
    check("resp_error", response_error, 32'(exp_err));
    check("resp_busy", request_ready, 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", response_valid, 1);
      check("hold_data", response_read_data, exp_data);
      check("hold_error", response_error, 32'(exp_err));
      check("hold_busy", request_ready, 0);
    end
    response_ready = 1'b1;
    tick();
    response_ready = 1'b0;
    check_idle_outputs("post");
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, DEPTH - 1)) << 2;
    case ($urandom_range(0, 3))
      0: a = $urandom;
      1: a = a | 32'($urandom_range(1, 3));
      default: ;
    endcase
    return a;
  endfunction

  initial begin
    reset = 1'b1;
    request_valid = 1'b0; request_write = 1'b0;
    request_address = 32'd0; request_write_data = 32'd0; response_ready = 1'b0;
    request_valid_z = 1'b0; request_write_z = 1'b0;
    request_address_z = 32'd0; request_write_data_z = 32'd0; response_ready_z = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();
    check_idle_outputs("after_reset");

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) do_txn(1'b1, 32'(i) << 2, $urandom, 0);

    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 0);
    do_txn(1'b0, 32'h10, 32'd0, 0);
    do_txn(1'b0, 32'h20, 32'd0, 5);

    // Reset in WAIT drops the pending store.
    request_valid = 1'b1; request_write = 1'b1;
    request_address = 32'h04; request_write_data = 32'h12345678; response_ready = 1'b1;
    tick();
    request_valid = 1'b0;
    check("rst_wait_busy", request_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    response_ready = 1'b0;
    check_idle_outputs("rst_wait");
    do_txn(1'b0, 32'h04, 32'd0, 1);

    // Reset wins over a simultaneous request.
    request_valid = 1'b1; request_write = 1'b1;
    request_address = 32'h08; request_write_data = 32'hA5A5A5A5;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    request_valid = 1'b0;
    check_idle_outputs("rst_prio");
    tick();
    check_idle_outputs("rst_prio2");
    do_txn(1'b0, 32'h08, 32'd0, 0);

    do_txn(1'b1, 32'h102, 32'hCAFEF00D, 0);
    do_txn(1'b1, 32'h100, 32'h0BADF00D, 0);
    do_txn(1'b0, 32'h00, 32'd0, 0);
    do_txn(1'b0, 32'h102, 32'd0, 0);
    do_txn(1'b0, 32'h3C, 32'd0, 2);

    for (int i = 0; i < 150; i++)
      do_txn(1'($urandom), rand_addr(), $urandom, $urandom_range(0, 3));

    // Zero wait states: back-to-back requests every two cycles.
    response_ready_z = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp_z;
      request_valid_z      = 1'b1;
      request_write_z      = (i < 4);
      request_address_z    = 32'(i % 4) << 2;
      request_write_data_z = $urandom;
      exp_z = (i < 4) ? 32'd0 : model_mem_z[i % 4];
      if (i < 4) model_mem_z[i] = request_write_data_z;
      txn_count++;
      $display("txn %0d zero-wait %s addr=%h exp_data=%h", txn_count,
               (i < 4) ? "store" : "load ", request_address_z, exp_z);
      check("z_idle_ready", request_ready_z, 1);
      tick();
      request_write_data_z = $urandom;
      check("z_resp_valid", response_valid_z, 1);
      check("z_busy", request_ready_z, 0);
      check("z_resp_data", response_read_data_z, exp_z);
      check("z_resp_error", response_error_z, 0);
      tick();
      check("z_done_valid", response_valid_z, 0);
    end
    request_valid_z = 1'b0;
    response_ready_z = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words stored; power of two, minimum 4.
REQ-002 Parameter WAIT_STATES, default 2: extra cycles between request acceptance and the response; range 0..15.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 request_valid  input  1  initiator presents a request.
REQ-006 request_ready  output  1  responder can accept a request this cycle.
REQ-007 request_write  input  1  1 = store, 0 = load.
REQ-008 request_address  input  32  byte address.
REQ-009 request_write_data  input  32  store data.
REQ-010 response_valid  output  1  response is present.
REQ-011 response_ready  input  1  initiator accepts the response.
REQ-012 response_read_data  output  32  load data; 0 for stores.
REQ-013 response_error  output  1  the request was rejected (see Configuration).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, RESPOND.
REQ-015 request_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with request_valid=1 and request_ready=1.
REQ-016 On acceptance, the block SHALL register write, address and write data; later changes to request_* inputs have no effect.
REQ-017 Transitions: IDLE->WAIT on acceptance when WAIT_STATES>0, else IDLE->RESPOND; WAIT->RESPOND when the wait counter reaches 0; RESPOND->IDLE when response_ready=1.
REQ-018 On entering WAIT, the wait counter SHALL load WAIT_STATES-1 and decrement once per cycle in WAIT.
REQ-019 For a request accepted at edge T, response_valid SHALL rise at edge T+1+WAIT_STATES.
REQ-020 The store SHALL commit to memory on the edge that enters RESPOND; the load SHALL sample memory on that same edge.
REQ-021 Word index = registered address bits [log2(DEPTH)+1:2].
REQ-022 response_valid, response_read_data and response_error SHALL be held stable while in RESPOND until the handshake completes.
REQ-023 If response_ready is already 1 when RESPOND is entered, the handshake SHALL complete on the first RESPOND cycle; IDLE follows on the next edge.
REQ-024 Peak throughput SHALL be one transaction per WAIT_STATES+2 cycles; there is no request pipelining.
REQ-025 Outside RESPOND, response_valid=0, response_error=0 and response_read_data=0.

Reset
REQ-026 reset=1 SHALL force IDLE, clear the wait counter and drive request_ready=1, response_valid=0, response_read_data=0 and response_error=0 on the next edge.
REQ-027 Reset during WAIT SHALL discard the pending store; memory is unmodified.
REQ-028 Reset SHALL take priority over every handshake in the same cycle.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro DATA_MEMORY_ERROR_CHECK_EN SHALL select address checking.
REQ-031 Defined: a request with address[1:0] != 0 or address[31:2] >= DEPTH SHALL complete with response_error=1, response_read_data=0 and no memory write, with unchanged latency.
REQ-032 Undefined: upper address bits and address[1:0] are ignored (index wraps modulo DEPTH) and response_error is tied to 0.

Verification
REQ-033 Defaults: store 0xDEADBEEF to 0x10 accepted at cycle 5, then a load from 0x10 -> load response_valid at cycle T+3 with read_data 0xDEADBEEF, error 0.
REQ-034 WAIT_STATES=0: load accepted at cycle T -> response_valid at T+1; request_ready=0 at T+1; back-to-back requests are accepted every 2 cycles while response_ready is held at 1.
REQ-035 Load from 0x20, response_ready held low 5 cycles -> response_valid and data stable for all 5 cycles; request_ready stays 0 until 1 cycle after the handshake.
REQ-036 Store 0x12345678 to 0x04, reset asserted during WAIT -> outputs return to reset values; a later load from 0x04 returns the prior contents.
REQ-037 With DATA_MEMORY_ERROR_CHECK_EN: store to 0x102 -> response_error=1, no write. Without it: store to 0x100 (DEPTH=64) aliases word 0, and a load from 0x00 returns the stored value.
